maxpool2d_0: RTL and testbench

- 2x2, stride-2 max-pooling stage directly downstream of the first 4-channel conv2d layer.
- Consumes that layer's raster-order, post-ReLU 4-channel pixel stream (output_valid / o_sof / d_out[3:0]).
- Emits a half-width, half-height 4-channel stream in the same handshake format, so the next conv layer can attach unchanged.
- Streaming, one pixel per valid beat, no backpressure; a single line buffer holds per-channel horizontal maxima of the even row.

---
 rtl/pool_pkg.sv | 22 ++
 rtl/pool_linebuf.sv | 39 +++
 rtl/maxpool2d_0.sv | 179 +++++++++++++++++
 tb/tb_maxpool2d_0.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types and helpers for the 2x2 stride-2 max-pooling stage.
package pool_pkg;

    // Default channel count and sample width of the pooling datapath.
    localparam int POOL_NUM_CH = 4;
    localparam int POOL_DATA_W = 32;

    // One signed channel sample.
    typedef logic signed [POOL_DATA_W-1:0] data_t;

    // Frame-tracking FSM: IDLE waits for sof, ACTIVE walks the frame.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Signed maximum; on a tie both operands are equal so either is returned.
    function automatic data_t max_d(input data_t a, input data_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_linebuf.sv
// Line buffer holding the per-channel horizontal maxima of the even row.
// One write port, one combinational read port so the vertical compare
// happens in the same cycle as the odd-row input beat.
module pool_linebuf
    import pool_pkg::*;
#(
    parameter int DEPTH  = 32,
    parameter int NUM_CH = POOL_NUM_CH,
    parameter int AW     = 5
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  data_t         wr_data [NUM_CH-1:0],
    input  logic [AW-1:0] rd_addr,
    output data_t         rd_data [NUM_CH-1:0]
);

    // Storage needs no reset: every slot is written on the even row before
    // the odd row reads it.
    data_t mem [0:DEPTH-1][0:NUM_CH-1];

    // Write one pooled-column entry (all channels) per even-row odd-col beat.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                mem[wr_addr][ch] <= wr_data[ch];
            end
        end
    end

    // Asynchronous read of the entry for the current pooled column.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            rd_data[ch] = mem[rd_addr][ch];
        end
    end

endmodule

// File: rtl/maxpool2d_0.sv
// 2x2, stride-2 max-pooling stage for a raster-order multi-channel pixel
// stream. Consumes one pixel per valid beat (no backpressure) and emits one
// pooled pixel one cycle after every odd-row, odd-column input beat.
//
// Handshake: a beat is transferred in every cycle where input_valid is 1;
// sof is only meaningful together with input_valid. On the output side
// output_valid is a single-cycle pulse qualifying d_out, o_sof and o_eof;
// there is no ready signal in either direction.
module maxpool2d_0
    import pool_pkg::*;
#(
    parameter int NUM_CH = POOL_NUM_CH,
    parameter int DATA_W = POOL_DATA_W,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     input_valid,
    input  logic                     sof,
    input  logic signed [DATA_W-1:0] d_in [NUM_CH-1:0],
    output logic                     output_valid,
    output logic                     o_sof,
    output logic                     o_eof,
    output logic signed [DATA_W-1:0] d_out [NUM_CH-1:0],
    output state_t                   fsm_state
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int HALF_W = IMG_W / 2;
    localparam int AW = CW - 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_ONE  = CW'(1);

    // Elaboration-time sanity checks on the geometry and sample type.
    if ((IMG_W % 2) != 0 || IMG_W < 4) begin : g_bad_width
        $error("maxpool2d_0: IMG_W must be even and at least 4");
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_height
        $error("maxpool2d_0: IMG_H must be even and at least 2");
    end
    if (DATA_W != POOL_DATA_W) begin : g_bad_data_w
        $error("maxpool2d_0: DATA_W must match pool_pkg::POOL_DATA_W");
    end

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;

    logic          accept;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          frame_last;
    logic          lb_wr;
    logic          emit;
    logic [AW-1:0] lb_addr;

    data_t hold_q  [NUM_CH-1:0];
    data_t hmax    [NUM_CH-1:0];
    data_t lb_rd   [NUM_CH-1:0];
    data_t pooled  [NUM_CH-1:0];

    assign fsm_state = state_q;

    // Position of the current beat: a sof beat is always (0,0), which is
    // how a mid-frame sof resynchronises the counters.
    always_comb begin
        cur_col    = sof ? '0 : col_q;
        cur_row    = sof ? '0 : row_q;
        frame_last = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        lb_addr    = cur_col[CW-1:1];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: enter on sof, leave after the last pixel of the frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (input_valid && sof) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (accept && frame_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: which beats are processed and what they do.
    always_comb begin
        accept = input_valid && (sof || (state_q == ACTIVE));
        lb_wr  = accept && cur_col[0] && !cur_row[0];
        emit   = accept && cur_col[0] && cur_row[0];
    end

    // Column/row counters advance only on processed beats.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col_q <= '0;
                row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
            end else begin
                col_q <= cur_col + 1'b1;
                row_q <= cur_row;
            end
        end
    end

    // Even-column samples wait here for their odd-column partner.
    always_ff @(posedge clk) begin
        if (accept && !cur_col[0]) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                hold_q[ch] <= d_in[ch];
            end
        end
    end

    // Horizontal max of the pixel pair, then vertical max against the line.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            hmax[ch]   = max_d(hold_q[ch], d_in[ch]);
            pooled[ch] = max_d(hmax[ch], lb_rd[ch]);
        end
    end

    pool_linebuf #(
        .DEPTH  (HALF_W),
        .NUM_CH (NUM_CH),
        .AW     (AW)
    ) u_linebuf (
        .clk     (clk),
        .wr_en   (lb_wr),
        .wr_addr (lb_addr),
        .wr_data (hmax),
        .rd_addr (lb_addr),
        .rd_data (lb_rd)
    );

    // Registered output: one-cycle pulse per pooled pixel, data held between.
    always_ff @(posedge clk) begin
        if (!rst) begin
            output_valid <= 1'b0;
            o_sof        <= 1'b0;
            o_eof        <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                d_out[ch] <= '0;
            end
        end else begin
            output_valid <= emit;
            o_sof        <= emit && (cur_row == ROW_ONE) && (cur_col == COL_ONE);
            o_eof        <= emit && frame_last;
            if (emit) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    d_out[ch] <= pooled[ch];
                end
            end
        end
    end

endmodule

// File: tb/tb_maxpool2d_0.sv
// Directed bench for maxpool2d_0: a 4x4 instance for the table-driven
// vectors and corner sequences, a 64x64 instance for resync and
// back-to-back full frames.
module tb_maxpool2d_0;
    import pool_pkg::*;

    localparam int EW = 130;                 // {sof, eof, 4 x 32-bit data}
    localparam int LW = 64;

    typedef logic [3:0][31:0] px4_t;

    typedef struct {
        logic sof;
        px4_t px;
        logic ev;
        logic esof;
        logic eeof;
        px4_t ed;
    } vec_t;

    // Clock / reset
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Small (4x4) instance
    logic                valid_s = 1'b0;
    logic                sof_s   = 1'b0;
    px4_t                px_s    = '0;
    logic signed [31:0]  din_s  [3:0];
    logic signed [31:0]  dout_s [3:0];
    px4_t                dout_s_p;
    logic                ov_s, osof_s, oeof_s;
    state_t              st_s;

    // Large (64x64) instance
    logic                valid_l = 1'b0;
    logic                sof_l   = 1'b0;
    px4_t                px_l    = '0;
    logic signed [31:0]  din_l  [3:0];
    logic signed [31:0]  dout_l [3:0];
    px4_t                dout_l_p;
    logic                ov_l, osof_l, oeof_l;
    state_t              st_l;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            din_s[k]    = px_s[k];
            din_l[k]    = px_l[k];
            dout_s_p[k] = dout_s[k];
            dout_l_p[k] = dout_l[k];
        end
    end

    maxpool2d_0 #(.NUM_CH(4), .DATA_W(32), .IMG_W(4), .IMG_H(4)) dut_s (
        .clk          (clk),
        .rst          (rst),
        .input_valid  (valid_s),
        .sof          (sof_s),
        .d_in         (din_s),
        .output_valid (ov_s),
        .o_sof        (osof_s),
        .o_eof        (oeof_s),
        .d_out        (dout_s),
        .fsm_state    (st_s)
    );

    maxpool2d_0 #(.NUM_CH(4), .DATA_W(32), .IMG_W(64), .IMG_H(64)) dut_l (
        .clk          (clk),
        .rst          (rst),
        .input_valid  (valid_l),
        .sof          (sof_l),
        .d_in         (din_l),
        .output_valid (ov_l),
        .o_sof        (osof_l),
        .o_eof        (oeof_l),
        .d_out        (dout_l),
        .fsm_state    (st_l)
    );

    // Scoreboard
    logic [EW-1:0] exp_q[$];
    int   checks = 0;
    int   errors = 0;
    px4_t last_s = '0;
    px4_t last_l = '0;
    int   out_cnt_l = 0;

    vec_t basic_tab  [16];
    vec_t signed_tab [16];

    function automatic px4_t px4(input int a, input int b, input int c, input int d);
        px4_t r;
        r[0] = 32'(a);
        r[1] = 32'(b);
        r[2] = 32'(c);
        r[3] = 32'(d);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, got, want);
        end
    endtask

    // Compare one cycle of DUT output against the scoreboard.
    task automatic check_out(input string nm, input logic ev, input logic act_v,
                             input logic act_sof, input logic act_eof,
                             input px4_t act_d, inout px4_t last);
        logic [EW-1:0] e;
        chk({nm, ".valid"}, 128'(act_v), 128'(ev));
        if (ev) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s.queue got empty want entry", nm);
            end else begin
                e = exp_q.pop_front();
                chk({nm, ".data"}, act_d, e[127:0]);
                chk({nm, ".sof"}, 128'(act_sof), 128'(e[129]));
                chk({nm, ".eof"}, 128'(act_eof), 128'(e[128]));
                last = e[127:0];
            end
        end else begin
            chk({nm, ".sof_idle"}, 128'(act_sof), 128'(0));
            chk({nm, ".eof_idle"}, 128'(act_eof), 128'(0));
            chk({nm, ".hold"}, act_d, last);
        end
    endtask

    // Driver: one cycle on the small instance, checked #1 after the edge.
    task automatic beat_s(input logic v, input logic s, input px4_t px,
                          input logic ev, input logic esof, input logic eeof, input px4_t ed);
        @(negedge clk);
        valid_s = v;
        sof_s   = s;
        px_s    = px;
        if (ev) exp_q.push_back({esof, eeof, ed});
        @(posedge clk);
        #1;
        check_out("s", ev, ov_s, osof_s, oeof_s, dout_s_p, last_s);
    endtask

    task automatic idle_s();
        beat_s(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Driver: one cycle on the large instance.
    task automatic beat_l(input logic v, input logic s, input px4_t px,
                          input logic ev, input logic esof, input logic eeof, input px4_t ed);
        @(negedge clk);
        valid_l = v;
        sof_l   = s;
        px_l    = px;
        if (ev) exp_q.push_back({esof, eeof, ed});
        @(posedge clk);
        #1;
        if (ov_l) out_cnt_l++;
        check_out("l", ev, ov_l, osof_l, oeof_l, dout_l_p, last_l);
    endtask

    // Apply nbeats rows of a small table, optionally with random idle gaps.
    task automatic run_small(input int sel, input bit gaps, input int nbeats);
        vec_t v;
        int   n;
        for (int i = 0; i < nbeats; i++) begin
            if (sel == 0) v = basic_tab[i];
            else          v = signed_tab[i];
            if (gaps) begin
                n = $urandom_range(0, 3);
                repeat (n) idle_s();
            end
            beat_s(1'b1, v.sof, v.px, v.ev, v.esof, v.eeof, v.ed);
        end
    endtask

    // Full 64x64 frame. Mode 0 ramps up (max is bottom-right of each window),
    // mode 1 ramps down through negatives (max is top-left).
    task automatic frame_l(input int mode);
        px4_t px, ed;
        int   base;
        logic ev;
        for (int r = 0; r < LW; r++) begin
            for (int c = 0; c < LW; c++) begin
                base = r * LW + c;
                ev   = (r % 2 == 1) && (c % 2 == 1);
                for (int k = 0; k < 4; k++) begin
                    if (mode == 0) begin
                        px[k] = 32'(base + 1000 * k);
                        ed[k] = 32'(base + 1000 * k);
                    end else begin
                        px[k] = 32'(-base - 1000 * k);
                        ed[k] = 32'(-((r - 1) * LW + (c - 1)) - 1000 * k);
                    end
                end
                beat_l(1'b1, (r == 0 && c == 0), px, ev,
                       (r == 1 && c == 1), (r == LW - 1 && c == LW - 1), ed);
            end
        end
    endtask

    // Hold reset low for n cycles and check the cleared state of both DUTs.
    task automatic do_reset(input int n);
        @(negedge clk);
        rst     = 1'b0;
        valid_s = 1'b0;
        sof_s   = 1'b0;
        valid_l = 1'b0;
        sof_l   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst.s.valid", 128'({ov_s, osof_s, oeof_s}), 128'(0));
        chk("rst.s.data", dout_s_p, 128'(0));
        chk("rst.s.state", 128'(st_s), 128'(IDLE));
        chk("rst.l.valid", 128'({ov_l, osof_l, oeof_l}), 128'(0));
        chk("rst.l.data", dout_l_p, 128'(0));
        chk("rst.l.state", 128'(st_l), 128'(IDLE));
        last_s = '0;
        last_l = '0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sv0 [16];
        sv0 = '{-7, -3, -5, -5, -9, -1, -5, -5, 10, -20, -4, -8, 3, -30, -2, -6};

        // Vector tables
        for (int i = 0; i < 16; i++) begin
            basic_tab[i].sof  = (i == 0);
            basic_tab[i].px   = px4(i, 100 + i, 200 + i, 300 + i);
            basic_tab[i].ev   = 1'b0;
            basic_tab[i].esof = 1'b0;
            basic_tab[i].eeof = 1'b0;
            basic_tab[i].ed   = '0;
            signed_tab[i].sof  = (i == 0);
            signed_tab[i].px   = px4(sv0[i], -sv0[i], sv0[i] + 1000, sv0[i] - 1000);
            signed_tab[i].ev   = 1'b0;
            signed_tab[i].esof = 1'b0;
            signed_tab[i].eeof = 1'b0;
            signed_tab[i].ed   = '0;
        end
        basic_tab[5].ev  = 1'b1; basic_tab[5].esof = 1'b1;
        basic_tab[5].ed  = px4(5, 105, 205, 305);
        basic_tab[7].ev  = 1'b1; basic_tab[7].ed  = px4(7, 107, 207, 307);
        basic_tab[13].ev = 1'b1; basic_tab[13].ed = px4(13, 113, 213, 313);
        basic_tab[15].ev = 1'b1; basic_tab[15].eeof = 1'b1;
        basic_tab[15].ed = px4(15, 115, 215, 315);

        signed_tab[5].ev  = 1'b1; signed_tab[5].esof = 1'b1;
        signed_tab[5].ed  = px4(-1, 9, 999, -1001);
        signed_tab[7].ev  = 1'b1; signed_tab[7].ed  = px4(-5, 5, 995, -1005);
        signed_tab[13].ev = 1'b1; signed_tab[13].ed = px4(10, 30, 1010, -990);
        signed_tab[15].ev = 1'b1; signed_tab[15].eeof = 1'b1;
        signed_tab[15].ed = px4(-2, 8, 998, -1002);

        // Reset state
        do_reset(2);

        // Basic 4x4 frame, continuous
        run_small(0, 1'b0, 16);
        idle_s();
        chk("s.state_end", 128'(st_s), 128'(IDLE));

        // Signed compare and ties
        run_small(1, 1'b0, 16);
        idle_s();

        // Gapped input
        run_small(0, 1'b1, 16);
        repeat (2) idle_s();

        // Junk before sof, partial frame, resync with a full frame
        for (int i = 0; i < 5; i++) beat_s(1'b1, 1'b0, px4(900, 901, 902, 903), 1'b0, 1'b0, 1'b0, '0);
        run_small(1, 1'b0, 5);
        run_small(0, 1'b0, 16);
        idle_s();

        // Reset mid-frame, then a full frame
        run_small(1, 1'b0, 10);
        do_reset(1);
        run_small(0, 1'b0, 16);
        idle_s();

        // Large: junk, sof + 5 beats, then two back-to-back full frames
        for (int i = 0; i < 5; i++) beat_l(1'b1, 1'b0, px4(-50, 50, -60, 60), 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) beat_l(1'b1, (i == 0), px4(4000, 4000, 4000, 4000), 1'b0, 1'b0, 1'b0, '0);
        out_cnt_l = 0;
        frame_l(0);
        chk("l.count_f1", 128'(out_cnt_l), 128'(1024));
        out_cnt_l = 0;
        frame_l(1);
        chk("l.count_f2", 128'(out_cnt_l), 128'(1024));
        beat_l(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
        chk("l.state_end", 128'(st_l), 128'(IDLE));
        chk("exp_q.empty", 128'(exp_q.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
